ctrl_pkt_gen: RTL and testbench
===============================

Name: ctrl_pkt_gen

Overview:
Control-path transmitter for the RMT pipeline. Converts single table/config write requests into 2-beat UDP/IPv4 control packets on a 512-bit AXI-Stream. The receive side (packet filter into parser/stage control ports) separates these packets from data traffic and consumes them. The block sits on the host/management side and feeds the RMT ingress stream through an arbiter.

Parameters:
C_S_AXIS_DATA_WIDTH, 512, AXIS data width; only 512 supported.
C_S_AXIS_TUSER_WIDTH, 128, AXIS tuser width.
ENTRY_WIDTH, 256, config payload bits; multiple of 8, at most 512.
CTRL_UDP_PORT, 16'hF1F2, UDP destination port that marks control packets.
SRC_PORT, 8'h01, value driven on tuser[23:16].

Ports:
clk  in  1  single clock for all logic
areset  in  1  reset, asynchronous, active-high
cfg_valid  in  1  write request valid
cfg_ready  out  1  write request accepted when cfg_valid and cfg_ready are both high
cfg_stage_id  in  8  target stage index
cfg_res_type  in  8  target resource type (key extractor, mask, lookup, action RAM)
cfg_index  in  16  entry index
cfg_data  in  ENTRY_WIDTH  entry contents
m_axis_tdata  out  512  packet data; byte k = tdata[8k+7:8k]
m_axis_tkeep  out  64  byte enables
m_axis_tuser  out  128  metadata
m_axis_tvalid  out  1  beat valid
m_axis_tready  in  1  downstream ready
m_axis_tlast  out  1  final beat

Behaviour:
- Reset values: cfg_ready=0 while areset is high, then 1 from the first clk after release. m_axis_tvalid=0, m_axis_tlast=0. tdata, tkeep and tuser are all 0. State=IDLE, seq=0.
- FSM states:
  - IDLE: cfg_ready=1. On cfg_valid, latch all cfg_* fields and go to HDR.
  - HDR: drive beat 0 with tvalid=1, tlast=0. On tready, go to PAY.
  - PAY: drive beat 1 with tvalid=1, tlast=1. On tready, increment seq and go to IDLE.
- cfg_ready is high only in IDLE. Throughput is at most 1 packet per 3 cycles with no stall.
- Latency: beat 0 is valid on the cycle after the cfg handshake.
- AXIS rules:
  - Once tvalid is asserted, tdata, tkeep, tuser and tlast hold stable until tready.
  - tvalid never drops mid-packet except on reset.
  - tready arriving without tvalid is ignored.
- Beat 0 layout, tkeep all ones, network byte order:
  - bytes 0-11: MAC addresses, 0.
  - bytes 12-13: 0x08,0x00.
  - byte 14: 0x45.
  - bytes 16-17: IP total length = 50+ENTRY_WIDTH/8.
  - byte 22: TTL 0x40.
  - byte 23: protocol 0x11.
  - bytes 36-37: CTRL_UDP_PORT.
  - bytes 38-39: UDP length = 30+ENTRY_WIDTH/8.
  - byte 42: stage_id.
  - byte 43: res_type.
  - bytes 44-45: index.
  - byte 46: seq field.
  - all other bytes 0 (checksums 0).
- Beat 1 layout: tdata[ENTRY_WIDTH-1:0]=cfg_data, upper bits 0. tkeep = low ENTRY_WIDTH/8 bits set.
- tuser on both beats: [15:0] = 64+ENTRY_WIDTH/8, [23:16] = SRC_PORT, remaining bits 0.
- Arithmetic: lengths are computed in 16 bits at elaboration. seq is 8 bits and wraps 255 to 0.
- Reset mid-packet: outputs clear asynchronously and the partial packet is abandoned (no tlast is sent). The latched request is discarded. seq returns to 0.
- A request arriving while not in IDLE stays pending on cfg_valid; it is not lost.

Optional Feature:
CTRL_PKT_SEQ_EN:
- Defined: byte 46 carries the seq counter, which increments per completed packet.
- Undefined: byte 46 = 0 and no seq register is synthesised.

Decomposition:
- Package rmt_ctrl_pkg holds:
  - ethertype, IP protocol and default UDP port constants;
  - byte offsets 12, 16, 23, 36, 38, 42-46;
  - FSM state enum {IDLE, HDR, PAY};
  - tuser field positions.
- One sub-module, ctrl_hdr_builder: purely combinational. Takes the latched stage_id, res_type, index and seq and produces the 512-bit beat-0 vector.

Test Plan:
- Single write: stage 2, type 1, index 0x0005, data 256'hA5…A5, tready tied 1. Expect:
  - beat 0 one cycle after the handshake, bytes 36-37 = F1 F2, bytes 42-45 = 02 01 00 05;
  - beat 1 with tlast=1, tkeep=64'h0000_0000_FFFF_FFFF;
  - tuser[15:0]=96.
- Backpressure: hold tready=0 for 5 cycles during HDR. tdata and tvalid stay stable; cfg_ready stays 0; beat 1 appears only after tready rises.
- Back-to-back: cfg_valid held with 3 requests. cfg_ready pulses every 3 cycles; 6 beats total, correct tlast on beats 2, 4 and 6.
- Sequence wrap (CTRL_PKT_SEQ_EN defined): send 257 packets. Byte 46 reads 0x00…0xFF then 0x00. With the macro undefined, byte 46 is always 0.
- Reset mid-packet: assert areset while in PAY with tready=0. tvalid falls without a clock edge; after release, the next request produces seq 0 and a full 2-beat packet.

Source files
------------

// File: rtl/rmt_ctrl_pkg.sv
// rmt_ctrl_pkg: shared constants, header byte offsets, FSM state encoding
// and tuser field positions for the control packet generator.
package rmt_ctrl_pkg;

    localparam logic [15:0] ETHERTYPE_IPV4        = 16'h0800;
    localparam logic [7:0]  IP_VER_IHL            = 8'h45;
    localparam logic [7:0]  IP_TTL                = 8'h40;
    localparam logic [7:0]  IP_PROTO_UDP          = 8'h11;
    localparam logic [15:0] DEFAULT_CTRL_UDP_PORT = 16'hF1F2;

    // Byte offsets within beat 0 (byte k = tdata[8k+7:8k]).
    localparam int OFS_ETHERTYPE  = 12;
    localparam int OFS_IP_VER_IHL = 14;
    localparam int OFS_IP_TOT_LEN = 16;
    localparam int OFS_IP_TTL     = 22;
    localparam int OFS_IP_PROTO   = 23;
    localparam int OFS_UDP_DPORT  = 36;
    localparam int OFS_UDP_LEN    = 38;
    localparam int OFS_STAGE_ID   = 42;
    localparam int OFS_RES_TYPE   = 43;
    localparam int OFS_INDEX      = 44;
    localparam int OFS_SEQ        = 46;

    // Length bases; each length adds ENTRY_WIDTH/8 payload bytes.
    localparam int IP_LEN_BASE    = 50;
    localparam int UDP_LEN_BASE   = 30;
    localparam int TUSER_LEN_BASE = 64;

    localparam int TUSER_LEN_LSB = 0;
    localparam int TUSER_SRC_LSB = 16;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        PAY
    } state_t;

    function automatic logic [15:0] len16(input int base, input int entry_width);
        return 16'(base + entry_width / 8);
    endfunction

    // Place a 16-bit field so its MSB lands in the lower-addressed byte.
    function automatic logic [15:0] net16(input logic [15:0] x);
        return {x[7:0], x[15:8]};
    endfunction

endpackage

// File: rtl/ctrl_hdr_builder.sv
// ctrl_hdr_builder: combinational assembly of beat 0 (Ethernet/IPv4/UDP
// header plus control fields) of a control packet.
// Ports:
//   stage_id, res_type, index, seq : latched request fields and sequence
//   hdr                            : 512-bit beat-0 data, byte k = hdr[8k+7:8k]
module ctrl_hdr_builder
    import rmt_ctrl_pkg::*;
#(
    parameter int          ENTRY_WIDTH   = 256,
    parameter logic [15:0] CTRL_UDP_PORT = DEFAULT_CTRL_UDP_PORT
) (
    input  logic [7:0]   stage_id,
    input  logic [7:0]   res_type,
    input  logic [15:0]  index,
    input  logic [7:0]   seq,
    output logic [511:0] hdr
);

    localparam logic [15:0] IP_TOT_LEN = len16(IP_LEN_BASE, ENTRY_WIDTH);
    localparam logic [15:0] UDP_LEN    = len16(UDP_LEN_BASE, ENTRY_WIDTH);

    always_comb begin
        hdr = '0;
        hdr[8*OFS_ETHERTYPE  +: 16] = net16(ETHERTYPE_IPV4);
        hdr[8*OFS_IP_VER_IHL +: 8]  = IP_VER_IHL;
        hdr[8*OFS_IP_TOT_LEN +: 16] = net16(IP_TOT_LEN);
        hdr[8*OFS_IP_TTL     +: 8]  = IP_TTL;
        hdr[8*OFS_IP_PROTO   +: 8]  = IP_PROTO_UDP;
        hdr[8*OFS_UDP_DPORT  +: 16] = net16(CTRL_UDP_PORT);
        hdr[8*OFS_UDP_LEN    +: 16] = net16(UDP_LEN);
        hdr[8*OFS_STAGE_ID   +: 8]  = stage_id;
        hdr[8*OFS_RES_TYPE   +: 8]  = res_type;
        hdr[8*OFS_INDEX      +: 16] = net16(index);
        hdr[8*OFS_SEQ        +: 8]  = seq;
    end

endmodule

// File: rtl/ctrl_pkt_gen.sv
// ctrl_pkt_gen: turns one config write request into a 2-beat UDP/IPv4
// control packet on a 512-bit AXI-Stream.
// Ports:
//   clk, areset        : clock, async active-high reset
//   cfg_*              : write request (valid/ready handshake + fields)
//   m_axis_*           : AXI-Stream master output
// Build option: define CTRL_PKT_SEQ_EN to carry a per-packet sequence
// counter in byte 46; otherwise byte 46 is 0 and no counter exists.
//
// state | meaning
// IDLE  | ready for a request (cfg_ready high once out of reset)
// HDR   | presenting beat 0 (header), waiting for tready
// PAY   | presenting beat 1 (payload, tlast), waiting for tready
module ctrl_pkt_gen
    import rmt_ctrl_pkg::*;
#(
    parameter int          C_S_AXIS_DATA_WIDTH  = 512,
    parameter int          C_S_AXIS_TUSER_WIDTH = 128,
    parameter int          ENTRY_WIDTH          = 256,
    parameter logic [15:0] CTRL_UDP_PORT        = DEFAULT_CTRL_UDP_PORT,
    parameter logic [7:0]  SRC_PORT             = 8'h01
) (
    input  logic                                 clk,
    input  logic                                 areset,
    input  logic                                 cfg_valid,
    output logic                                 cfg_ready,
    input  logic [7:0]                           cfg_stage_id,
    input  logic [7:0]                           cfg_res_type,
    input  logic [15:0]                          cfg_index,
    input  logic [ENTRY_WIDTH-1:0]               cfg_data,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]       m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]     m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser,
    output logic                                 m_axis_tvalid,
    input  logic                                 m_axis_tready,
    output logic                                 m_axis_tlast
);

    localparam int KEEP_W = C_S_AXIS_DATA_WIDTH / 8;
    localparam logic [15:0] TUSER_LEN = len16(TUSER_LEN_BASE, ENTRY_WIDTH);
    localparam logic [KEEP_W-1:0] PAY_KEEP =
        {KEEP_W{1'b1}} >> (KEEP_W - ENTRY_WIDTH / 8);
    localparam logic [C_S_AXIS_TUSER_WIDTH-1:0] TUSER_VAL =
        (C_S_AXIS_TUSER_WIDTH'(SRC_PORT)  << TUSER_SRC_LSB) |
        (C_S_AXIS_TUSER_WIDTH'(TUSER_LEN) << TUSER_LEN_LSB);

    state_t                 state_q, state_d;
    logic                   rdy_en_q;
    logic [7:0]             stage_q, res_q;
    logic [15:0]            index_q;
    logic [ENTRY_WIDTH-1:0] data_q;
    logic [7:0]             seq;
    logic                   cfg_fire;
    logic [511:0]           hdr_beat;

    assign cfg_fire = (state_q == IDLE) && rdy_en_q && cfg_valid;

    // rdy_en_q keeps cfg_ready low until the first clock after reset release.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q  <= IDLE;
            rdy_en_q <= 1'b0;
            stage_q  <= '0;
            res_q    <= '0;
            index_q  <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            rdy_en_q <= 1'b1;
            if (cfg_fire) begin
                stage_q <= cfg_stage_id;
                res_q   <= cfg_res_type;
                index_q <= cfg_index;
                data_q  <= cfg_data;
            end
        end
    end

`ifdef CTRL_PKT_SEQ_EN
    logic [7:0] seq_q;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            seq_q <= '0;
        end else if (state_q == PAY && m_axis_tready) begin
            seq_q <= seq_q + 8'd1;
        end
    end

    assign seq = seq_q;
`else
    assign seq = '0;
`endif

    ctrl_hdr_builder #(
        .ENTRY_WIDTH   (ENTRY_WIDTH),
        .CTRL_UDP_PORT (CTRL_UDP_PORT)
    ) u_hdr (
        .stage_id (stage_q),
        .res_type (res_q),
        .index    (index_q),
        .seq      (seq),
        .hdr      (hdr_beat)
    );

    // Outputs decode straight from registered state and latched fields, so
    // they hold while stalled and clear asynchronously with reset.
    always_comb begin
        state_d       = state_q;
        cfg_ready     = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tuser  = '0;
        case (state_q)
            IDLE: begin
                cfg_ready = rdy_en_q;
                if (cfg_fire) state_d = HDR;
            end
            HDR: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = hdr_beat;
                m_axis_tkeep  = '1;
                m_axis_tuser  = TUSER_VAL;
                if (m_axis_tready) state_d = PAY;
            end
            PAY: begin
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = 1'b1;
                m_axis_tdata[ENTRY_WIDTH-1:0] = data_q;
                m_axis_tkeep  = PAY_KEEP;
                m_axis_tuser  = TUSER_VAL;
                if (m_axis_tready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ctrl_pkt_gen.sv
// tb_ctrl_pkt_gen: scoreboard bench for ctrl_pkt_gen. Accepted requests push
// the two expected beats (built byte-by-byte from the packet format) into a
// queue; a negedge monitor pops and compares on every output transfer.
module tb_ctrl_pkt_gen;

    localparam int EW = 256;

    typedef struct packed {
        logic [511:0] d;
        logic [63:0]  k;
        logic [127:0] u;
        logic         l;
    } beat_t;

    logic           clk = 1'b0;
    logic           areset = 1'b1;
    logic           cfg_valid = 1'b0;
    logic           cfg_ready;
    logic [7:0]     cfg_stage_id = '0;
    logic [7:0]     cfg_res_type = '0;
    logic [15:0]    cfg_index = '0;
    logic [EW-1:0]  cfg_data = '0;
    logic [511:0]   m_axis_tdata;
    logic [63:0]    m_axis_tkeep;
    logic [127:0]   m_axis_tuser;
    logic           m_axis_tvalid;
    logic           m_axis_tready = 1'b0;
    logic           m_axis_tlast;

    beat_t expq[$];
    int    checks = 0;
    int    failures = 0;
    int    seq_model = 0;
    int    cyc = 0;
    logic  rnd_ready = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ctrl_pkt_gen dut (
        .clk           (clk),
        .areset        (areset),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_stage_id  (cfg_stage_id),
        .cfg_res_type  (cfg_res_type),
        .cfg_index     (cfg_index),
        .cfg_data      (cfg_data),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast)
    );

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [127:0] exp_tuser();
        return 128'(64 + EW / 8) | (128'h01 << 16);
    endfunction

    function automatic beat_t exp_hdr(input logic [7:0] s, input logic [7:0] r,
                                      input logic [15:0] idx, input int sq);
        logic [7:0] b [64];
        int ip_len, udp_len;
        beat_t x;
        ip_len  = 50 + EW / 8;
        udp_len = 30 + EW / 8;
        foreach (b[i]) b[i] = 8'h00;
        b[12] = 8'h08; b[13] = 8'h00; b[14] = 8'h45;
        b[16] = 8'(ip_len / 256);  b[17] = 8'(ip_len % 256);
        b[22] = 8'h40; b[23] = 8'h11;
        b[36] = 8'hF1; b[37] = 8'hF2;
        b[38] = 8'(udp_len / 256); b[39] = 8'(udp_len % 256);
        b[42] = s; b[43] = r;
        b[44] = idx[15:8]; b[45] = idx[7:0];
`ifdef CTRL_PKT_SEQ_EN
        b[46] = 8'(sq % 256);
`else
        b[46] = 8'(sq * 0);
`endif
        x.d = '0;
        for (int i = 0; i < 64; i++) x.d[8*i +: 8] = b[i];
        x.k = '1;
        x.u = exp_tuser();
        x.l = 1'b0;
        return x;
    endfunction

    function automatic beat_t exp_pay(input logic [EW-1:0] data);
        beat_t x;
        x.d = '0;
        x.d[EW-1:0] = data;
        x.k = '0;
        for (int i = 0; i < EW / 8; i++) x.k[i] = 1'b1;
        x.u = exp_tuser();
        x.l = 1'b1;
        return x;
    endfunction

    // Monitor: latency, stall stability, mutual exclusion, scoreboard pops,
    // and pushes of expected beats on each accepted request.
    initial begin
        logic  hs_prev;
        logic  stall_prev;
        beat_t last_out;
        beat_t e;
        hs_prev = 1'b0;
        stall_prev = 1'b0;
        last_out = '0;
        forever begin
            @(negedge clk);
            if (areset) begin
                hs_prev = 1'b0;
                stall_prev = 1'b0;
            end else begin
                if (hs_prev) begin
                    chk("latency_tvalid", 512'(m_axis_tvalid), 512'(1));
                    chk("latency_tlast", 512'(m_axis_tlast), 512'(0));
                end
                if (stall_prev) begin
                    chk("hold_tvalid", 512'(m_axis_tvalid), 512'(1));
                    chk("hold_tdata", m_axis_tdata, last_out.d);
                    chk("hold_tkeep", 512'(m_axis_tkeep), 512'(last_out.k));
                    chk("hold_tuser", 512'(m_axis_tuser), 512'(last_out.u));
                    chk("hold_tlast", 512'(m_axis_tlast), 512'(last_out.l));
                end
                chk("ready_vs_tvalid", 512'(cfg_ready & m_axis_tvalid), 512'(0));
                if (m_axis_tvalid && m_axis_tready) begin
                    if (expq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_beat actual=beat required=none tdata=%0h", m_axis_tdata);
                    end else begin
                        e = expq.pop_front();
                        chk("beat_tdata", m_axis_tdata, e.d);
                        chk("beat_tkeep", 512'(m_axis_tkeep), 512'(e.k));
                        chk("beat_tuser", 512'(m_axis_tuser), 512'(e.u));
                        chk("beat_tlast", 512'(m_axis_tlast), 512'(e.l));
                    end
                end
                stall_prev = m_axis_tvalid && !m_axis_tready;
                last_out.d = m_axis_tdata;
                last_out.k = m_axis_tkeep;
                last_out.u = m_axis_tuser;
                last_out.l = m_axis_tlast;
                hs_prev = cfg_valid && cfg_ready;
                if (hs_prev) begin
                    expq.push_back(exp_hdr(cfg_stage_id, cfg_res_type, cfg_index, seq_model));
                    expq.push_back(exp_pay(cfg_data));
                    seq_model = (seq_model + 1) % 256;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) m_axis_tready = ($urandom_range(0, 3) != 0);
        end
    end

    function automatic logic [EW-1:0] rnd_data();
        logic [EW-1:0] v;
        for (int i = 0; i < EW / 32; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // Present a request and hold it until accepted; returns at posedge+1.
    task automatic wait_accept();
        logic ok;
        ok = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            if (cfg_ready) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=no_ready required=ready");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [7:0] s, input logic [7:0] r,
                           input logic [15:0] idx, input logic [EW-1:0] d);
        cfg_stage_id = s;
        cfg_res_type = r;
        cfg_index    = idx;
        cfg_data     = d;
        cfg_valid    = 1'b1;
    endtask

    task automatic send(input logic [7:0] s, input logic [7:0] r,
                        input logic [15:0] idx, input logic [EW-1:0] d);
        set_req(s, r, idx, d);
        wait_accept();
        cfg_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (expq.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (expq.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d required=0 beats_left", expq.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int hs_cyc [3];
        logic [EW-1:0] pat;

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        chk("rst_cfg_ready", 512'(cfg_ready), 512'(0));
        chk("rst_tvalid", 512'(m_axis_tvalid), 512'(0));
        chk("rst_tlast", 512'(m_axis_tlast), 512'(0));
        chk("rst_tdata", m_axis_tdata, 512'(0));
        chk("rst_tkeep", 512'(m_axis_tkeep), 512'(0));
        chk("rst_tuser", 512'(m_axis_tuser), 512'(0));
        @(posedge clk);
        #1;
        areset = 1'b0;
        @(negedge clk);
        chk("ready_before_first_clk", 512'(cfg_ready), 512'(0));
        @(posedge clk);
        #1;
        chk("ready_after_release", 512'(cfg_ready), 512'(1));

        // Single write
        for (int i = 0; i < EW / 8; i++) pat[8*i +: 8] = 8'hA5;
        m_axis_tready = 1'b1;
        send(8'd2, 8'd1, 16'h0005, pat);
        drain();

        // Backpressure during HDR
        m_axis_tready = 1'b0;
        send(8'($urandom), 8'($urandom), 16'($urandom), rnd_data());
        cfg_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        chk("stall_beats_pending", 512'(expq.size()), 512'(2));
        m_axis_tready = 1'b1;
        drain();

        // Back-to-back with cfg_valid held
        for (int i = 0; i < 3; i++) begin
            set_req(8'($urandom), 8'($urandom), 16'($urandom), rnd_data());
            wait_accept();
            hs_cyc[i] = cyc;
        end
        cfg_valid = 1'b0;
        chk("b2b_spacing_1", 512'(hs_cyc[1] - hs_cyc[0]), 512'(3));
        chk("b2b_spacing_2", 512'(hs_cyc[2] - hs_cyc[1]), 512'(3));
        drain();

        // Random traffic long enough to wrap the sequence counter
        rnd_ready = 1'b1;
        for (int p = 0; p < 262; p++) begin
            send(8'($urandom), 8'($urandom), 16'($urandom), rnd_data());
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        drain();
        rnd_ready = 1'b0;
        #1;

        // Reset while stalled in PAY
        m_axis_tready = 1'b0;
        send(8'($urandom), 8'($urandom), 16'($urandom), rnd_data());
        m_axis_tready = 1'b1;
        @(posedge clk);
        #1;
        m_axis_tready = 1'b0;
        @(negedge clk);
        #1;
        chk("pay_before_reset_tlast", 512'(m_axis_tlast), 512'(1));
        #1;
        areset = 1'b1;
        #1;
        chk("async_rst_tvalid", 512'(m_axis_tvalid), 512'(0));
        chk("async_rst_tlast", 512'(m_axis_tlast), 512'(0));
        chk("async_rst_tdata", m_axis_tdata, 512'(0));
        chk("async_rst_cfg_ready", 512'(cfg_ready), 512'(0));
        expq.delete();
        seq_model = 0;
        repeat (2) @(posedge clk);
        #1;
        areset = 1'b0;
        @(posedge clk);
        #1;
        m_axis_tready = 1'b1;
        send(8'($urandom), 8'($urandom), 16'($urandom), rnd_data());
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
